// File: rtl/ifu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ifu_pkg
//  Description : Shared constants and FSM state encoding for the instruction
//                fetch unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package ifu_pkg;

  // Default address / instruction widths.
  localparam int unsigned ADDR_WIDTH_DEF = 32;
  localparam int unsigned DATA_WIDTH_DEF = 32;

  // PC loaded on reset.
  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;

  // Bytes per instruction word; the PC advances by this much per delivery.
  localparam int unsigned INST_BYTES = 4;

  // Fetch FSM: REQ issues the request, WAIT holds for the response,
  // HOLD presents the buffered word to the decoder.
  typedef logic [1:0] ifu_state_t;
  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

endpackage : ifu_pkg
`default_nettype wire

// File: rtl/ifu_inst_buf.sv
`default_nettype none
// ============================================================================
//  Module      : ifu_inst_buf
//  Description : One-entry holding register for a fetched instruction word,
//                its PC and its fault flag. Load captures, clear empties.
//  Revision    : 1.0 - initial release
// ============================================================================
module ifu_inst_buf #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic                  clear_i,
  input  logic [DATA_WIDTH-1:0] inst_i,
  input  logic [ADDR_WIDTH-1:0] inst_pc_i,
  input  logic                  inst_fault_i,
  output logic [DATA_WIDTH-1:0] inst_o,
  output logic [ADDR_WIDTH-1:0] inst_pc_o,
  output logic                  inst_fault_o
);

  logic [DATA_WIDTH-1:0] inst_q;
  logic [ADDR_WIDTH-1:0] inst_pc_q;
  logic                  inst_fault_q;

  // Capture on load, zero on reset or clear; otherwise hold steady.
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_fault_q <= 1'b0;
    end else if (load_i) begin
      inst_q       <= inst_i;
      inst_pc_q    <= inst_pc_i;
      inst_fault_q <= inst_fault_i;
    end
  end

  assign inst_o       = inst_q;
  assign inst_pc_o    = inst_pc_q;
  assign inst_fault_o = inst_fault_q;

endmodule : ifu_inst_buf
`default_nettype wire

// File: rtl/ifu_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : ifu_fetch
//  Description : Instruction fetch unit. Holds the PC, issues one request at
//                a time to instruction memory, buffers the returned word and
//                hands it to the decoder over valid/ready. A redirect loads a
//                new PC and squashes any fetch in flight.
//  Revision    : 1.0 - initial release
// ============================================================================
module ifu_fetch
  import ifu_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned           DATA_WIDTH = DATA_WIDTH_DEF,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(RESET_PC_DEF)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req_valid_o,
  input  logic                  imem_req_ready_i,
  output logic [ADDR_WIDTH-1:0] imem_req_addr_o,
  input  logic                  imem_rsp_valid_i,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data_i,
  input  logic                  imem_rsp_err_i,
  input  logic                  redirect_valid_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  output logic                  inst_valid_o,
  input  logic                  inst_ready_i,
  output logic [DATA_WIDTH-1:0] inst_o,
  output logic [ADDR_WIDTH-1:0] inst_pc_o,
  output logic                  inst_fault_o,
  output logic [31:0]           fetch_cnt_o
);

  localparam logic [ADDR_WIDTH-1:0] C_PC_STEP  = ADDR_WIDTH'(INST_BYTES);
  localparam logic [ADDR_WIDTH-1:0] C_PC_ALIGN = ~ADDR_WIDTH'(INST_BYTES - 1);

  ifu_state_t            state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  drop_q, drop_d;
  logic [31:0]           cnt_q, cnt_d;

  logic                  w_buf_load;
  logic                  w_buf_clear;
  logic [ADDR_WIDTH-1:0] w_redirect_pc;
  logic                  w_inst_valid;
  logic [DATA_WIDTH-1:0] w_buf_inst;
  logic [ADDR_WIDTH-1:0] w_buf_pc;
  logic                  w_buf_fault;

  // Redirect targets are word aligned; the low byte-offset bits are discarded.
  assign w_redirect_pc = redirect_pc_i & C_PC_ALIGN;

  // A redirect in the HOLD cycle kills the word, so it is never offered.
  assign w_inst_valid = (state_q == S_HOLD) && !redirect_valid_i;

  // Next-state logic; redirect outranks every other event in the same cycle.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_d      = drop_q;
    cnt_d       = cnt_q;
    w_buf_load  = 1'b0;
    w_buf_clear = 1'b0;
    case (state_q)
      S_REQ: begin
        if (imem_req_ready_i) begin
          state_d = S_WAIT;
        end
        if (redirect_valid_i) begin
          // An accepted request went out at the old PC; its word is stale.
          pc_d = w_redirect_pc;
          if (imem_req_ready_i) begin
            drop_d = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid_i) begin
          if (drop_q || redirect_valid_i) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            w_buf_load = 1'b1;
            state_d    = S_HOLD;
          end
        end
        if (redirect_valid_i) begin
          pc_d = w_redirect_pc;
          if (!imem_rsp_valid_i) begin
            drop_d = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (redirect_valid_i) begin
          w_buf_clear = 1'b1;
          pc_d        = w_redirect_pc;
          state_d     = S_REQ;
        end else if (inst_ready_i) begin
          pc_d    = pc_q + C_PC_STEP;
          cnt_d   = cnt_q + 32'd1;
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  // Architectural state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      drop_q  <= 1'b0;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
      cnt_q   <= cnt_d;
    end
  end

  ifu_inst_buf #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_inst_buf (
    .clk          (clk),
    .rst          (rst),
    .load_i       (w_buf_load),
    .clear_i      (w_buf_clear),
    .inst_i       (imem_rsp_data_i),
    .inst_pc_i    (pc_q),
    .inst_fault_i (imem_rsp_err_i),
    .inst_o       (w_buf_inst),
    .inst_pc_o    (w_buf_pc),
    .inst_fault_o (w_buf_fault)
  );

  // Every output reads as zero while reset is held.
  assign imem_req_valid_o = !rst && (state_q == S_REQ);
  assign imem_req_addr_o  = rst ? '0 : pc_q;
  assign inst_valid_o     = !rst && w_inst_valid;
  assign inst_o           = rst ? '0 : w_buf_inst;
  assign inst_pc_o        = rst ? '0 : w_buf_pc;
  assign inst_fault_o     = !rst && w_buf_fault;
  assign fetch_cnt_o      = rst ? 32'd0 : cnt_q;

endmodule : ifu_fetch
`default_nettype wire

// File: tb/tb_ifu_fetch.sv
`timescale 1ns/1ps
module tb_ifu_fetch;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid, inst_ready;
  logic [31:0] inst, inst_pc;
  logic        inst_fault;
  logic [31:0] fetch_cnt;

  always #5 clk = ~clk;

  ifu_fetch dut (
    .clk              (clk),
    .rst              (rst),
    .imem_req_valid_o (imem_req_valid),
    .imem_req_ready_i (imem_req_ready),
    .imem_req_addr_o  (imem_req_addr),
    .imem_rsp_valid_i (imem_rsp_valid),
    .imem_rsp_data_i  (imem_rsp_data),
    .imem_rsp_err_i   (imem_rsp_err),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .inst_valid_o     (inst_valid),
    .inst_ready_i     (inst_ready),
    .inst_o           (inst),
    .inst_pc_o        (inst_pc),
    .inst_fault_o     (inst_fault),
    .fetch_cnt_o      (fetch_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Instruction memory model
  bit          mem_busy;
  logic [31:0] mem_addr;
  int          mem_lat;
  int          lat_min, lat_max;

  // Transaction-level reference: next fetch address, one outstanding request
  // (possibly squashed), one word waiting for the decoder, delivered count.
  bit          m_held;
  logic [31:0] m_held_pc;
  bit          m_out;
  logic [31:0] m_out_addr;
  bit          m_squash;
  logic [31:0] m_pc;
  logic [31:0] m_cnt;

  // Observed outputs and expectations for the current cycle
  logic        s_req_valid, s_inst_valid, s_fault;
  logic [31:0] s_addr, s_inst, s_inst_pc, s_cnt;
  logic        e_req_valid, e_inst_valid, e_held;
  logic [31:0] e_addr, e_cnt, e_inst, e_inst_pc;
  logic        e_fault;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return a * 32'h0019_660D + 32'h3C6E_F35F;
  endfunction

  function automatic logic memerr(input logic [31:0] a);
    return a[5:2] == 4'h4;
  endfunction

  // One clock: drive inputs on the falling edge, sample, derive the expected
  // outputs, then advance memory and reference across the rising edge.
  task automatic cycle(input logic r, input logic rdy, input logic irdy,
                       input logic rv, input logic [31:0] rpc);
    logic rsp;
    logic [31:0] tgt;
    @(negedge clk);
    rsp            = !r && mem_busy && (mem_lat == 0);
    rst            = r;
    imem_req_ready = rdy;
    inst_ready     = irdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? memw(mem_addr) : $urandom;
    imem_rsp_err   = rsp ? memerr(mem_addr) : 1'($urandom);
    #1;
    s_req_valid  = imem_req_valid;
    s_addr       = imem_req_addr;
    s_inst_valid = inst_valid;
    s_inst       = inst;
    s_inst_pc    = inst_pc;
    s_fault      = inst_fault;
    s_cnt        = fetch_cnt;

    if (r) begin
      e_req_valid = 0; e_addr = 0; e_inst_valid = 0; e_held = 0;
      e_inst = 0; e_inst_pc = 0; e_fault = 0; e_cnt = 0;
    end else begin
      e_req_valid  = !m_held && !m_out;
      e_addr       = m_pc;
      e_held       = m_held;
      e_inst_valid = m_held && !rv;
      e_inst       = memw(m_held_pc);
      e_inst_pc    = m_held_pc;
      e_fault      = memerr(m_held_pc);
      e_cnt        = m_cnt;
    end

    tgt = {rpc[31:2], 2'b00};
    if (r) begin
      m_held = 0; m_out = 0; m_squash = 0; m_pc = RST_PC; m_cnt = 0;
      mem_busy = 0;
    end else begin
      if (rsp) mem_busy = 0;
      else if (mem_busy) mem_lat--;
      if (s_req_valid && rdy) begin
        mem_busy = 1;
        mem_addr = s_addr;
        mem_lat  = $urandom_range(lat_max, lat_min);
      end
      if (m_held) begin
        if (rv) begin
          m_held = 0; m_pc = tgt;
        end else if (irdy) begin
          m_held = 0; m_cnt = m_cnt + 1; m_pc = m_held_pc + 32'd4;
        end
      end else if (m_out) begin
        if (rsp) begin
          m_out = 0;
          if (!m_squash && !rv) begin
            m_held = 1; m_held_pc = m_out_addr;
          end
          if (rv) m_pc = tgt;
        end else if (rv) begin
          m_squash = 1; m_pc = tgt;
        end
      end else begin
        if (rdy) begin
          m_out = 1; m_out_addr = m_pc; m_squash = rv;
        end
        if (rv) m_pc = tgt;
      end
    end
  endtask

  task automatic test_reset();
    lat_min = 0; lat_max = 0;
    cycle(1, 1, 1, 0, 0);
    cycle(1, 1, 1, 1, 32'h1234_5678);
    n_checks++;
    if ({s_req_valid, s_addr, s_inst_valid, s_inst, s_inst_pc, s_fault, s_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs_zero: got req=%b addr=%h iv=%b inst=%h pc=%h f=%b cnt=%0d want all 0",
               s_req_valid, s_addr, s_inst_valid, s_inst, s_inst_pc, s_fault, s_cnt);
    end
    cycle(0, 0, 0, 0, 0);
    n_checks++;
    if (s_req_valid !== 1'b1 || s_addr !== RST_PC) begin
      n_fail++;
      $display("FAIL reset_first_req: got req=%b addr=%h want req=1 addr=%h", s_req_valid, s_addr, RST_PC);
    end
    n_checks++;
    if ({s_inst_valid, s_inst, s_inst_pc, s_fault, s_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_buffer: got iv=%b inst=%h pc=%h f=%b cnt=%0d want all 0",
               s_inst_valid, s_inst, s_inst_pc, s_fault, s_cnt);
    end
  endtask

  task automatic test_stream();
    logic [31:0] addrs[$];
    logic [31:0] want [3];
    int got = 0, cyc = 0;
    want[0] = 32'h8000_0000; want[1] = 32'h8000_0004; want[2] = 32'h8000_0008;
    while (cyc < 30 && got < 3) begin
      cycle(0, 1, 1, 0, 0);
      cyc++;
      if (s_req_valid) addrs.push_back(s_addr);
      if (s_inst_valid) begin
        got++;
        n_checks++;
        if (s_inst !== memw(s_inst_pc) || s_fault !== 1'b0) begin
          n_fail++;
          $display("FAIL stream_word: got inst=%h f=%b want inst=%h f=0", s_inst, s_fault, memw(s_inst_pc));
        end
      end
    end
    n_checks++;
    if (got != 3 || cyc != 9) begin
      n_fail++;
      $display("FAIL stream_throughput: got %0d words in %0d cycles want 3 in 9", got, cyc);
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (i >= addrs.size() || addrs[i] !== want[i]) begin
        n_fail++;
        $display("FAIL stream_addr%0d: got %h want %h", i, (i < addrs.size()) ? addrs[i] : 32'hx, want[i]);
      end
    end
    cycle(0, 0, 0, 0, 0);
    n_checks++;
    if (s_cnt !== 32'd3 || s_addr !== 32'h8000_000C) begin
      n_fail++;
      $display("FAIL stream_cnt: got cnt=%0d addr=%h want cnt=3 addr=8000000c", s_cnt, s_addr);
    end
  endtask

  task automatic test_stall();
    logic [31:0] w, p;
    int b = 0;
    do begin cycle(0, 1, 0, 0, 0); b++; end while (!s_inst_valid && b < 10);
    w = memw(32'h8000_000C); p = 32'h8000_000C;
    for (int i = 0; i < 5; i++) begin
      cycle(0, 1, 0, 0, 0);
      n_checks++;
      if (s_inst_valid !== 1'b1 || s_inst !== w || s_inst_pc !== p || s_req_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold%0d: got iv=%b inst=%h pc=%h req=%b want iv=1 inst=%h pc=%h req=0",
                 i, s_inst_valid, s_inst, s_inst_pc, s_req_valid, w, p);
      end
    end
    cycle(0, 1, 1, 0, 0);
    cycle(0, 0, 0, 0, 0);
    n_checks++;
    if (s_cnt !== 32'd4 || s_req_valid !== 1'b1 || s_addr !== p + 32'd4) begin
      n_fail++;
      $display("FAIL stall_release: got cnt=%0d req=%b addr=%h want cnt=4 req=1 addr=%h",
               s_cnt, s_req_valid, s_addr, p + 32'd4);
    end
  endtask

  task automatic test_redirect_wait();
    bit seen = 0, found = 0;
    lat_min = 2; lat_max = 2;
    cycle(0, 1, 0, 0, 0);
    cycle(0, 0, 1, 1, 32'h8000_0100);
    for (int i = 0; i < 12 && !found; i++) begin
      cycle(0, 0, 1, 0, 0);
      if (s_inst_valid) seen = 1;
      if (s_req_valid) found = 1;
    end
    n_checks++;
    if (seen || !found || s_addr !== 32'h8000_0100 || s_cnt !== 32'd4) begin
      n_fail++;
      $display("FAIL redirect_wait: got seen=%b found=%b addr=%h cnt=%0d want seen=0 found=1 addr=80000100 cnt=4",
               seen, found, s_addr, s_cnt);
    end
    lat_min = 0; lat_max = 0;
  endtask

  task automatic test_redirect_hold();
    int b = 0;
    do begin cycle(0, 1, 0, 0, 0); b++; end while (!s_inst_valid && b < 10);
    cycle(0, 0, 1, 1, 32'h8000_0203);
    n_checks++;
    if (s_inst_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL redirect_hold_valid: got inst_valid=%b want 0", s_inst_valid);
    end
    cycle(0, 0, 0, 0, 0);
    n_checks++;
    if (s_cnt !== 32'd4 || s_req_valid !== 1'b1 || s_addr !== 32'h8000_0200) begin
      n_fail++;
      $display("FAIL redirect_hold_next: got cnt=%0d req=%b addr=%h want cnt=4 req=1 addr=80000200",
               s_cnt, s_req_valid, s_addr);
    end
  endtask

  task automatic test_fault();
    int b = 0;
    cycle(0, 0, 0, 1, 32'h8000_0010);
    do begin cycle(0, 1, 1, 0, 0); b++; end while (!s_inst_valid && b < 10);
    n_checks++;
    if (s_inst_valid !== 1'b1 || s_fault !== 1'b1 || s_inst_pc !== 32'h8000_0010 || s_inst !== memw(32'h8000_0010)) begin
      n_fail++;
      $display("FAIL fault_word: got iv=%b f=%b pc=%h inst=%h want iv=1 f=1 pc=80000010 inst=%h",
               s_inst_valid, s_fault, s_inst_pc, s_inst, memw(32'h8000_0010));
    end
    cycle(0, 0, 0, 0, 0);
    n_checks++;
    if (s_addr !== 32'h8000_0014 || s_cnt !== 32'd5) begin
      n_fail++;
      $display("FAIL fault_next: got addr=%h cnt=%0d want addr=80000014 cnt=5", s_addr, s_cnt);
    end
  endtask

  task automatic test_wrap_and_reset();
    int b = 0;
    cycle(0, 0, 0, 1, 32'hFFFF_FFFC);
    do begin cycle(0, 1, 1, 0, 0); b++; end while (!s_inst_valid && b < 10);
    cycle(0, 0, 0, 0, 0);
    n_checks++;
    if (s_req_valid !== 1'b1 || s_addr !== 32'h0000_0000 || s_cnt !== 32'd6) begin
      n_fail++;
      $display("FAIL pc_wrap: got req=%b addr=%h cnt=%0d want req=1 addr=00000000 cnt=6", s_req_valid, s_addr, s_cnt);
    end
    lat_min = 3; lat_max = 3;
    cycle(0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    n_checks++;
    if (s_req_valid !== 1'b1 || s_addr !== RST_PC || s_cnt !== 32'd0 || s_inst_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_in_wait: got req=%b addr=%h cnt=%0d iv=%b want req=1 addr=%h cnt=0 iv=0",
               s_req_valid, s_addr, s_cnt, s_inst_valid, RST_PC);
    end
  endtask

  task automatic test_random();
    logic r, rdy, irdy, rv;
    lat_min = 0; lat_max = 3;
    for (int i = 0; i < 600; i++) begin
      r    = ($urandom_range(99, 0) == 0);
      rdy  = ($urandom_range(3, 0) != 0);
      irdy = ($urandom_range(2, 0) != 0);
      rv   = ($urandom_range(7, 0) == 0);
      cycle(r, rdy, irdy, rv, $urandom);
      n_checks++;
      if (s_req_valid !== e_req_valid || s_addr !== e_addr) begin
        n_fail++;
        $display("FAIL rand_req@%0d: got req=%b addr=%h want req=%b addr=%h", i, s_req_valid, s_addr, e_req_valid, e_addr);
      end
      n_checks++;
      if (s_inst_valid !== e_inst_valid || s_cnt !== e_cnt) begin
        n_fail++;
        $display("FAIL rand_deliver@%0d: got iv=%b cnt=%0d want iv=%b cnt=%0d", i, s_inst_valid, s_cnt, e_inst_valid, e_cnt);
      end
      if (e_held) begin
        n_checks++;
        if (s_inst !== e_inst || s_inst_pc !== e_inst_pc || s_fault !== e_fault) begin
          n_fail++;
          $display("FAIL rand_word@%0d: got inst=%h pc=%h f=%b want inst=%h pc=%h f=%b",
                   i, s_inst, s_inst_pc, s_fault, e_inst, e_inst_pc, e_fault);
        end
      end
    end
  endtask

  initial begin
    rst = 1; imem_req_ready = 0; inst_ready = 0; redirect_valid = 0; redirect_pc = 0;
    imem_rsp_valid = 0; imem_rsp_data = 0; imem_rsp_err = 0;
    mem_busy = 0; mem_addr = 0; mem_lat = 0; lat_min = 0; lat_max = 0;
    m_held = 0; m_held_pc = 0; m_out = 0; m_out_addr = 0; m_squash = 0; m_pc = RST_PC; m_cnt = 0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_wait();
    test_redirect_hold();
    test_fault();
    test_wrap_and_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
